// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS9 burst controller: FSM state encoding and default seed.
package prbs_pkg;

  localparam logic [8:0] DEFAULT_SEED = 9'h1AA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/prbs9.sv
// PRBS9 generator, x^9+x^5+1, Fibonacci form; output is taken before the shift.
module prbs9 #(
  parameter logic [8:0] SEED = 9'h1AA
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic dout
);

  logic [0:8] r;

  // Seed LSB lands in r[8], so the first nine outputs are the seed LSB-first.
  always_ff @(posedge clk) begin
    if (rst)
      r <= SEED;
    else if (en)
      r <= {r[8] ^ r[4], r[0:7]};
  end

  assign dout = r[8];

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Burst controller: emits burst_len PRBS9 bits, one every rate_div+1 clocks.
module prbs_burst_ctrl
  import prbs_pkg::*;
#(
  parameter logic [8:0] SEED  = DEFAULT_SEED,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [DIV_W-1:0] i_rate_div,
  input  logic [LEN_W-1:0] i_burst_len,
  output logic             o_bit,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state, nxt;
  logic [DIV_W-1:0] div, rate;
  logic [LEN_W-1:0] cnt, len;
  logic             last;
  logic             prbs_rst;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state <= ST_IDLE;
      div   <= '0;
      cnt   <= '0;
      rate  <= '0;
      len   <= '0;
    end else begin
      state <= nxt;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            rate <= i_rate_div;
            len  <= i_burst_len;
          end
        end
        ST_SEED: begin
          div <= '0;
          cnt <= '0;
        end
        ST_RUN: begin
          if (o_valid) begin
            div <= '0;
            cnt <= cnt + LEN_ONE;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs depend only on registered state/counters, never on inputs.
  assign o_valid = (state == ST_RUN) && (div == rate);
  assign o_busy  = (state == ST_SEED) || (state == ST_RUN);
  assign o_done  = (state == ST_DONE);
  assign last    = (cnt == len - LEN_ONE);

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_start)
          nxt = (i_burst_len == '0) ? ST_DONE : ST_SEED;
      end
      ST_SEED: nxt = i_abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (i_abort)
          nxt = ST_IDLE;
        else if (o_valid && last)
          nxt = ST_DONE;
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  assign prbs_rst = i_reset || (state == ST_SEED);

  prbs9 #(.SEED(SEED)) u_prbs9 (
    .clk  (clock),
    .rst  (prbs_rst),
    .en   (o_valid),
    .dout (o_bit)
  );

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Directed self-checking bench for prbs_burst_ctrl.
module tb_prbs_burst_ctrl;

  logic        clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [7:0]  i_rate_div = '0;
  logic [15:0] i_burst_len = '0;
  logic        o_bit, o_valid, o_busy, o_done;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic        s [0:511];

  prbs_burst_ctrl #(.SEED(9'h1AA), .DIV_W(8), .LEN_W(16)) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_rate_div  (i_rate_div),
    .i_burst_len (i_burst_len),
    .o_bit       (o_bit),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [8:0] seed;
    seed = 9'h1AA;
    for (int i = 0; i < 9; i++) s[i] = seed[i];
    for (int i = 9; i < 512; i++) s[i] = s[i-9] ^ s[i-5];

    // reset
    step();
    step();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy},  32'd0);
    chk("rst_done",  {31'd0, o_done},  32'd0);
    i_reset = 1'b0;
    step();

    // rate 0, len 9: nine consecutive valids carrying the seed LSB-first
    i_rate_div = 8'd0; i_burst_len = 16'd9; i_start = 1'b1;
    chk("a_idle_busy", {31'd0, o_busy}, 32'd0);
    step();
    i_start = 1'b0;
    chk("a_seed_busy",  {31'd0, o_busy},  32'd1);
    chk("a_seed_valid", {31'd0, o_valid}, 32'd0);
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("a_valid%0d", k), {31'd0, o_valid}, 32'd1);
      chk($sformatf("a_bit%0d", k),   {31'd0, o_bit},   {31'd0, s[k]});
    end
    step();
    chk("a_done",  {31'd0, o_done},  32'd1);
    chk("a_dbusy", {31'd0, o_busy},  32'd0);
    chk("a_dval",  {31'd0, o_valid}, 32'd0);
    step();
    chk("a_done_end", {31'd0, o_done}, 32'd0);

    // rate 3, len 4; start re-pulsed and config changed mid-burst must not matter
    i_rate_div = 8'd3; i_burst_len = 16'd4; i_start = 1'b1;
    for (int t = 1; t <= 19; t++) begin
      step();
      if (t == 1) i_start = 1'b0;
      if (t == 7) begin i_start = 1'b1; i_burst_len = 16'd10; i_rate_div = 8'd0; end
      if (t == 8) i_start = 1'b0;
      chk($sformatf("b_valid_t%0d", t), {31'd0, o_valid},
          (t == 5 || t == 9 || t == 13 || t == 17) ? 32'd1 : 32'd0);
      chk($sformatf("b_busy_t%0d", t), {31'd0, o_busy}, (t >= 1 && t <= 17) ? 32'd1 : 32'd0);
      chk($sformatf("b_done_t%0d", t), {31'd0, o_done}, (t == 18) ? 32'd1 : 32'd0);
      if (t == 5 || t == 9 || t == 13 || t == 17)
        chk($sformatf("b_bit_t%0d", t), {31'd0, o_bit}, {31'd0, s[(t - 5) / 4]});
    end

    // zero-length burst
    i_rate_div = 8'd0; i_burst_len = 16'd0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("c_done",  {31'd0, o_done},  32'd1);
    chk("c_busy",  {31'd0, o_busy},  32'd0);
    chk("c_valid", {31'd0, o_valid}, 32'd0);
    step();
    chk("c_done_end", {31'd0, o_done},  32'd0);
    chk("c_val_end",  {31'd0, o_valid}, 32'd0);

    // abort together with 3rd valid of a 10-bit burst
    i_rate_div = 8'd0; i_burst_len = 16'd10; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    chk("d_bit0", {31'd0, o_bit}, {31'd0, s[0]});
    step();
    chk("d_bit1", {31'd0, o_bit}, {31'd0, s[1]});
    step();
    i_abort = 1'b1;
    chk("d_abort_valid", {31'd0, o_valid}, 32'd1);
    chk("d_abort_bit",   {31'd0, o_bit},   {31'd0, s[2]});
    step();
    i_abort = 1'b0;
    chk("d_post_valid", {31'd0, o_valid}, 32'd0);
    chk("d_post_busy",  {31'd0, o_busy},  32'd0);
    chk("d_post_done",  {31'd0, o_done},  32'd0);
    step();
    chk("d_post2_done", {31'd0, o_done}, 32'd0);
    i_burst_len = 16'd3; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("d_re_valid%0d", k), {31'd0, o_valid}, 32'd1);
      chk($sformatf("d_re_bit%0d", k),   {31'd0, o_bit},   {31'd0, s[k]});
    end
    step();
    chk("d_re_done", {31'd0, o_done}, 32'd1);
    step();

    // full period plus one: bit 512 wraps back to bit 1
    i_rate_div = 8'd0; i_burst_len = 16'd512; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 512; k++) begin
      step();
      chk($sformatf("e_valid%0d", k), {31'd0, o_valid}, 32'd1);
      chk($sformatf("e_bit%0d", k),   {31'd0, o_bit},   {31'd0, s[k]});
    end
    step();
    chk("e_done", {31'd0, o_done}, 32'd1);
    step();

    // reset mid-burst overrides start/abort
    i_rate_div = 8'd1; i_burst_len = 16'd20; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int t = 2; t <= 7; t++) step();
    chk("f_valid_pre", {31'd0, o_valid}, 32'd1);
    i_reset = 1'b1; i_start = 1'b1; i_abort = 1'b1;
    step();
    i_reset = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    chk("f_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("f_rst_busy",  {31'd0, o_busy},  32'd0);
    chk("f_rst_done",  {31'd0, o_done},  32'd0);
    chk("f_rst_bit",   {31'd0, o_bit},   {31'd0, s[0]});
    step();
    chk("f_idle_busy", {31'd0, o_busy}, 32'd0);
    i_rate_div = 8'd0; i_burst_len = 16'd2; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("f_bit%0d", k), {31'd0, o_bit}, {31'd0, s[k]});
    end
    step();
    chk("f_done", {31'd0, o_done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
